// File: rtl/cve2_obi_arbiter.sv
// cve2_obi_arbiter: shares one OBI memory port between the core's instruction and data ports.
// Ports: clk_i/rst_ni clock and async active-low reset; instr_* fetch port (req/gnt/addr, rvalid/err/rdata);
// data_* load/store port (req/gnt/we/be/addr/wdata, rvalid/err/rdata); mem_* shared memory port;
// busy_o high while any accepted transaction awaits its response.
module cve2_obi_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic        instr_err_o,
  output logic [31:0] instr_rdata_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic        data_err_o,
  output logic [31:0] data_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);
  logic [2:0] count, wr_idx;
  logic [MaxOutstanding-1:0] ids, ids_n, wr_mask;
  logic locked, lock_id, rr_last, owner, owner_req, full, accept, pop;
  assign full = count == 3'(MaxOutstanding);
  assign owner = locked ? lock_id : (instr_req_i ^ data_req_i) ? data_req_i : ~rr_last;
  assign owner_req = owner ? data_req_i : instr_req_i;
  assign mem_req_o = (instr_req_i | data_req_i) & ~full;
  assign accept = mem_req_o & mem_gnt_i & rst_ni;
  assign pop = mem_rvalid_i & (count != 3'd0);
  assign instr_gnt_o = accept & ~owner;
  assign data_gnt_o = accept & owner;
  assign mem_addr_o = owner ? data_addr_i : instr_addr_i;
  assign mem_we_o = owner & data_we_i;
  assign mem_be_o = owner ? data_be_i : 4'hF;
  assign mem_wdata_o = owner ? data_wdata_i : 32'h0;
  assign instr_rvalid_o = pop & ~ids[0];
  assign data_rvalid_o = pop & ids[0];
  assign instr_err_o = instr_rvalid_o & mem_err_i;
  assign data_err_o = data_rvalid_o & mem_err_i;
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o = mem_rdata_i;
  assign busy_o = count != 3'd0;
  assign wr_idx = count - {2'b0, pop};
  assign wr_mask = MaxOutstanding'(1) << wr_idx;
  always_comb begin
    ids_n = pop ? ids >> 1 : ids;
    if (accept) ids_n = (ids_n & ~wr_mask) | ({MaxOutstanding{owner}} & wr_mask);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= 3'd0;
      ids <= '0;
      locked <= 1'b0;
      lock_id <= 1'b0;
      rr_last <= 1'b0;
    end else begin
      count <= count + {2'b0, accept} - {2'b0, pop};
      ids <= ids_n;
      if (accept) rr_last <= owner;
      if (accept | (locked & ~owner_req)) locked <= 1'b0;
      else if (mem_req_o & ~mem_gnt_i) begin
        locked <= 1'b1;
        lock_id <= owner;
      end
    end
  end
endmodule

// File: tb/tb_cve2_obi_arbiter.sv
// tb_cve2_obi_arbiter: directed stimulus with a response scoreboard for cve2_obi_arbiter.
module tb_cve2_obi_arbiter;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o, data_err_o;
  logic [3:0] data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i, busy_o;
  logic [3:0] mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  int passed = 0, total = 0;
  typedef struct packed {logic d; logic err; logic [31:0] rdata;} rsp_t;
  rsp_t exp_q[$];
  rsp_t e;
  cve2_obi_arbiter #(.MaxOutstanding(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_addr_i(instr_addr_i),
    .instr_rvalid_o(instr_rvalid_o), .instr_err_o(instr_err_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  always @(negedge clk_i) begin
    #2;
    if (instr_rvalid_o || data_rvalid_o) begin
      if (exp_q.size() == 0) chk("spurious_rvalid", 32'({instr_rvalid_o, data_rvalid_o}), 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_route", 32'({instr_rvalid_o, data_rvalid_o}), 32'({~e.d, e.d}));
        chk("rsp_err", 32'({instr_err_o, data_err_o}), 32'({~e.d & e.err, e.d & e.err}));
        chk("rsp_rdata_i", instr_rdata_o, e.rdata);
        chk("rsp_rdata_d", data_rdata_o, e.rdata);
      end
    end
  end
  task automatic idle();
    instr_req_i = 0; instr_addr_i = 0;
    data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
    mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = 0;
  endtask
  task automatic cyc();
    @(negedge clk_i);
    idle();
  endtask
  task automatic ireq(input logic [31:0] a);
    instr_req_i = 1; instr_addr_i = a;
  endtask
  task automatic dreq(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    data_req_i = 1; data_addr_i = a; data_we_i = we; data_be_i = be; data_wdata_i = wd;
  endtask
  task automatic rsp(input logic d, input logic err, input logic [31:0] rdata);
    mem_rvalid_i = 1; mem_err_i = err; mem_rdata_i = rdata;
    exp_q.push_back({d, err, rdata});
  endtask
  task automatic no_rvalid(input string name);
    chk(name, 32'({instr_rvalid_o, data_rvalid_o, instr_err_o, data_err_o}), 32'd0);
  endtask
  initial begin
    idle();
    cyc(); cyc(); #1;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_mem_req_idle", 32'(mem_req_o), 0);
    chk("rst_gnts_idle", 32'({instr_gnt_o, data_gnt_o}), 0);
    cyc(); ireq(32'h3000_0000); mem_gnt_i = 1; #1;
    chk("rst_mem_req", 32'(mem_req_o), 1);
    chk("rst_gnt_blocked", 32'({instr_gnt_o, data_gnt_o}), 0);
    cyc(); rst_ni = 1; ireq(32'h3000_0000); mem_gnt_i = 1; #1;
    chk("fetch_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    chk("fetch_addr", mem_addr_o, 32'h3000_0000);
    chk("fetch_be_we", 32'({mem_be_o, mem_we_o}), 32'b11110);
    chk("fetch_wdata", mem_wdata_o, 0);
    cyc(); rsp(0, 0, 32'h0000_0013); #1;
    chk("fetch_busy", 32'(busy_o), 1);
    cyc(); #1;
    chk("fetch_idle", 32'(busy_o), 0);
    cyc(); ireq(32'h100); dreq(32'h2000, 1, 4'h3, 32'hDEAD_BEEF); mem_gnt_i = 1; #1;
    chk("tie1_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b01);
    chk("tie1_addr", mem_addr_o, 32'h2000);
    chk("tie1_be_we", 32'({mem_be_o, mem_we_o}), 32'b00111);
    chk("tie1_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    cyc(); ireq(32'h100); dreq(32'h2000, 1, 4'h3, 32'hDEAD_BEEF); mem_gnt_i = 1; #1;
    chk("tie2_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    chk("tie2_addr", mem_addr_o, 32'h100);
    chk("tie2_be_we_wdata", 32'({mem_be_o, mem_we_o}) | mem_wdata_o, 32'b11110);
    cyc(); ireq(32'h100); dreq(32'h2000, 1, 4'h3, 32'hDEAD_BEEF); mem_gnt_i = 1; rsp(1, 0, 32'hAAAA_0001); #1;
    chk("full_mem_req", 32'(mem_req_o), 0);
    chk("full_gnts", 32'({instr_gnt_o, data_gnt_o}), 0);
    cyc(); ireq(32'h100); dreq(32'h2000, 1, 4'h3, 32'hDEAD_BEEF); mem_gnt_i = 1; rsp(0, 0, 32'hAAAA_0002); #1;
    chk("resume_mem_req", 32'(mem_req_o), 1);
    chk("tie3_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b01);
    cyc(); ireq(32'h100); dreq(32'h2000, 1, 4'h3, 32'hDEAD_BEEF); mem_gnt_i = 1; #1;
    chk("tie4_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    chk("tie4_busy", 32'(busy_o), 1);
    cyc(); rsp(1, 1, 32'hAAAA_0003);
    cyc(); rsp(0, 0, 32'hAAAA_0004);
    cyc(); #1;
    chk("tie_drained", 32'(busy_o), 0);
    cyc(); ireq(32'h40); mem_gnt_i = 1; #1;
    chk("ord_i_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    cyc(); dreq(32'h44, 0, 4'hF, 0); mem_gnt_i = 1; #1;
    chk("ord_d_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b01);
    cyc(); rsp(0, 0, 32'h11);
    cyc(); rsp(1, 1, 32'h22);
    cyc(); #1;
    chk("ord_drained", 32'(busy_o), 0);
    cyc(); dreq(32'h1000, 0, 4'hF, 0); #1;
    chk("lock0_addr", mem_addr_o, 32'h1000);
    chk("lock0_gnt", 32'({instr_gnt_o, data_gnt_o}), 0);
    for (int i = 1; i < 3; i++) begin
      cyc(); dreq(32'h1000, 0, 4'hF, 0); ireq(32'h50); #1;
      chk("lock_addr", mem_addr_o, 32'h1000);
      chk("lock_gnt", 32'({instr_gnt_o, data_gnt_o, mem_req_o}), 32'b001);
    end
    cyc(); dreq(32'h1000, 0, 4'hF, 0); ireq(32'h50); mem_gnt_i = 1; #1;
    chk("lock_release_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b01);
    chk("lock_release_addr", mem_addr_o, 32'h1000);
    cyc(); ireq(32'h50); mem_gnt_i = 1; #1;
    chk("after_lock_gnt", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    cyc(); rsp(1, 0, 32'h33);
    cyc(); rsp(0, 0, 32'h44);
    cyc(); #1;
    chk("lock_drained", 32'(busy_o), 0);
    cyc(); mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h55; #1;
    no_rvalid("spurious_outputs");
    chk("spurious_busy", 32'(busy_o), 0);
    cyc(); #1;
    chk("spurious_busy_next", 32'(busy_o), 0);
    cyc(); ireq(32'h60); mem_gnt_i = 1;
    cyc(); ireq(32'h64); mem_gnt_i = 1; #1;
    chk("pre_reset_busy", 32'(busy_o), 1);
    cyc(); rst_ni = 0; #1;
    chk("async_reset_busy", 32'(busy_o), 0);
    cyc(); rst_ni = 1; mem_rvalid_i = 1; #1;
    no_rvalid("post_reset_rsp1");
    chk("post_reset_busy", 32'(busy_o), 0);
    cyc(); mem_rvalid_i = 1; #1;
    no_rvalid("post_reset_rsp2");
    cyc(); ireq(32'h70); dreq(32'h3000, 0, 4'hF, 0); mem_gnt_i = 1; #1;
    chk("reset_tie1", 32'({instr_gnt_o, data_gnt_o}), 32'b01);
    cyc(); ireq(32'h70); dreq(32'h3000, 0, 4'hF, 0); mem_gnt_i = 1; #1;
    chk("reset_tie2", 32'({instr_gnt_o, data_gnt_o}), 32'b10);
    cyc(); rsp(1, 0, 32'h66);
    cyc(); rsp(0, 0, 32'h77);
    cyc(); #1;
    chk("final_busy", 32'(busy_o), 0);
    cyc(); cyc(); #1;
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/cve2_obi_arbiter.md
CVE2_OBI_ARBITER -- requirements
Module: cve2_obi_arbiter

Interface
REQ-001 Parameter MaxOutstanding, default 2, legal 1..4: maximum accepted-but-unanswered memory transactions.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 instr_req_i  input  1  fetch request from core instruction port.
REQ-005 instr_gnt_o  output  1  fetch accepted.
REQ-006 instr_addr_i  input  32  fetch address.
REQ-007 instr_rvalid_o, instr_err_o  output  1 each  fetch response valid, bus error.
REQ-008 instr_rdata_o  output  32  fetch read data.
REQ-009 data_req_i, data_we_i  input  1 each  load/store request, write enable.
REQ-010 data_be_i  input  4  byte enables; data_addr_i, data_wdata_i  input  32 each.
REQ-011 data_gnt_o, data_rvalid_o, data_err_o  output  1 each; data_rdata_o  output  32.
REQ-012 mem_req_o, mem_we_o  output  1 each; mem_be_o  output  4; mem_addr_o, mem_wdata_o  output  32 each: shared memory port.
REQ-013 mem_gnt_i, mem_rvalid_i, mem_err_i  input  1 each; mem_rdata_i  input  32.
REQ-014 busy_o  output  1  high while any transaction is outstanding.

Function
REQ-015 Protocol on all ports is req/gnt/rvalid (OBI-style); a transfer is accepted in a cycle where req and gnt are both high.
REQ-016 mem_req_o = (instr_req_i | data_req_i) & (count < MaxOutstanding), combinational.
REQ-017 Owner selection: if locked, the lock owner; else if only one requester is active, that requester; else (tie) the requester not recorded in rr_last.
REQ-018 mem_addr_o/we/be/wdata come from the owner; for instr owner: we=0, be=4'hF, wdata=0.
REQ-019 Owner's gnt_o = mem_gnt_i & mem_req_o; the non-owner's gnt_o = 0; no combinational path from mem_gnt_i to mem_req_o.
REQ-020 Lock: mem_req_o high and mem_gnt_i low sets lock to the owner at the next edge; lock clears on acceptance, or if the lock owner's req_i is low (violation recovery, released next cycle).
REQ-021 rr_last updates to the accepted owner on every acceptance.
REQ-022 On acceptance, push owner ID (1 bit) into an in-order ID FIFO of depth MaxOutstanding; count increments.
REQ-023 On mem_rvalid_i with count>0: pop head; drive rvalid_o and err_o (= mem_err_i) only to the head owner, same cycle (zero latency).
REQ-024 instr_rdata_o and data_rdata_o both equal mem_rdata_i at all times; only rvalid/err are gated.
REQ-025 Push and pop in the same cycle: count unchanged, FIFO order preserved.
REQ-026 Full (count==MaxOutstanding): mem_req_o=0 even if mem_rvalid_i pops this cycle (no bypass); requests resume the next cycle.
REQ-027 mem_rvalid_i with count==0: ignored, no rvalid_o, count stays 0.
REQ-028 busy_o = (count != 0), registered-state derived.

Reset
REQ-029 While rst_ni is low: count=0, FIFO empty, lock cleared, rr_last=instr (data wins first tie); all gnt/rvalid/err outputs 0, mem_req_o driven only by REQ-016 with count=0.
REQ-030 Reset asserted mid-transaction discards all outstanding IDs; responses arriving after reset release are treated per REQ-027.

Verification
REQ-031 Single fetch: instr_req_i=1, addr 0x30000000, mem_gnt_i=1 -> instr_gnt_o=1 same cycle, mem_addr_o=0x30000000, be=4'hF; rvalid next cycle with rdata 0x00000013 -> instr_rvalid_o=1, data_rvalid_o=0.
REQ-032 Tie after reset: both req, mem_gnt_i=1 -> data granted first, instr next cycle; sustained both-req alternates D,I,D,I.
REQ-033 Lock: data req at 0x1000, mem_gnt_i=0 for 3 cycles while instr also requests -> mem_addr_o stays 0x1000 until grant, instr_gnt_o=0 throughout.
REQ-034 Outstanding limit (MaxOutstanding=2): two accepted, no rvalid -> mem_req_o=0 on third request; rvalid in same cycle as third request still blocks; request issued the following cycle.
REQ-035 Ordering: accept I then D, return two rvalids with mem_err_i=0 then 1 -> instr_rvalid_o first (err 0), data_rvalid_o second with data_err_o=1.
REQ-036 Spurious rvalid at count 0 and reset with 2 outstanding -> no rvalid_o pulses, busy_o=0 after reset.
